// File: rtl/truth_table_sweeper.sv
// Programmable truth-table generator: one minterm mask per function, swept row by
// row over a valid/ready stream while per-function minterm counts accumulate.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_FUNC = 5,
    parameter int unsigned IDXW   = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [IDXW-1:0]      cfg_idx,
    input  logic [(1<<N_IN)-1:0] cfg_mask,
    input  logic                 start,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_IN-1:0]      out_row,
    output logic [N_FUNC-1:0]    out_val,
    output logic                 busy,
    output logic                 done,
    input  logic [IDXW-1:0]      cnt_sel,
    output logic [N_IN:0]        cnt_out
);

    localparam int unsigned ROWS = 1 << N_IN;
    localparam int unsigned CNTW = N_IN + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [N_IN-1:0]   row_q, row_d;
    logic [ROWS-1:0]   mask_q [N_FUNC];
    logic [ROWS-1:0]   mask_d [N_FUNC];
    logic [CNTW-1:0]   cnt_q  [N_FUNC];
    logic [CNTW-1:0]   cnt_d  [N_FUNC];
    logic              out_valid_q, out_valid_d;
    logic [N_IN-1:0]   out_row_q, out_row_d;
    logic [N_FUNC-1:0] out_val_q, out_val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;

    assign hs = out_valid_q & out_ready;

    // Next-state, mask/count updates and registered output values
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Indices with no matching function simply match nothing
                if (cfg_we) begin
                    for (int f = 0; f < int'(N_FUNC); f++) begin
                        if (cfg_idx == IDXW'(f)) begin
                            mask_d[f] = cfg_mask;
                        end
                    end
                end
                if (start) begin
                    state_d = ST_SWEEP;
                    row_d   = '0;
                    for (int f = 0; f < int'(N_FUNC); f++) begin
                        cnt_d[f] = '0;
                    end
                end
            end
            ST_SWEEP: begin
                if (hs) begin
                    for (int f = 0; f < int'(N_FUNC); f++) begin
                        cnt_d[f] = cnt_q[f] + CNTW'(mask_q[f][row_q]);
                    end
                    if (row_q == N_IN'(ROWS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d = row_q + N_IN'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they line up with it after the edge
        out_valid_d = (state_d == ST_SWEEP);
        busy_d      = (state_d == ST_SWEEP);
        done_d      = (state_d == ST_DONE);
        out_row_d   = '0;
        out_val_d   = '0;
        if (state_d == ST_SWEEP) begin
            out_row_d = row_d;
            for (int f = 0; f < int'(N_FUNC); f++) begin
                out_val_d[f] = mask_d[f][row_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_val_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int f = 0; f < int'(N_FUNC); f++) begin
                mask_q[f] <= '0;
                cnt_q[f]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_val_q   <= out_val_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int f = 0; f < int'(N_FUNC); f++) begin
                mask_q[f] <= mask_d[f];
                cnt_q[f]  <= cnt_d[f];
            end
        end
    end

    // Count readback; out-of-range selects read as zero
    always_comb begin
        cnt_out = '0;
        for (int f = 0; f < int'(N_FUNC); f++) begin
            if (cnt_sel == IDXW'(f)) begin
                cnt_out = cnt_q[f];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_val   = out_val_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: stimulus queues expected rows, a
// negedge monitor pops and compares them on every accepted handshake.
module tb_truth_table_sweeper;

    typedef struct packed {
        logic [2:0] row;
        logic [4:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [7:0] cfg_mask = '0;
    logic       start = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_row;
    logic [4:0] out_val;
    logic       busy;
    logic       done;
    logic [2:0] cnt_sel = '0;
    logic [3:0] cnt_out;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Hand-computed rows (bit f = function f) for masks 8A,54,B4,8E,C5
    logic [4:0] ev_def  [8] = '{5'b10000, 5'b01001, 5'b11110, 5'b01001,
                                5'b00110, 5'b00100, 5'b10010, 5'b11101};
    // Same masks with f0 = FF
    logic [4:0] ev_ff   [8] = '{5'b10001, 5'b01001, 5'b11111, 5'b01001,
                                5'b00111, 5'b00101, 5'b10011, 5'b11101};
    logic [4:0] ev_zero [8] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    int ec_def  [5] = '{3, 3, 4, 4, 4};
    int ec_ff   [5] = '{8, 3, 4, 4, 4};
    int ec_zero [5] = '{0, 0, 0, 0, 0};

    truth_table_sweeper #(.N_IN(3), .N_FUNC(5)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_mask(cfg_mask), .start(start), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_val(out_val),
        .busy(busy), .done(done), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted row must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_row: got row %0d val %b, expected nothing", out_row, out_val);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("row", 32'(out_row), 32'(e.row));
                chk("val", 32'(out_val), 32'(e.val));
            end
        end
    end

    task automatic wr(input logic [2:0] idx, input logic [7:0] m);
        cfg_we = 1'b1; cfg_idx = idx; cfg_mask = m;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic check_counts(input string name, input int ec [5]);
        for (int f = 0; f < 5; f++) begin
            cnt_sel = 3'(f);
            #1;
            chk(name, 32'(cnt_out), 32'(ec[f]));
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_valid"}, 32'(out_valid), 32'(0));
        chk({name, "_busy"},  32'(busy),      32'(0));
        chk({name, "_done"},  32'(done),      32'(0));
        chk({name, "_row"},   32'(out_row),   32'(0));
        chk({name, "_val"},   32'(out_val),   32'(0));
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            chk({name, "_cnt"}, 32'(cnt_out), 32'(0));
        end
    endtask

    // One sweep; optional stall at row 2, start/cfg pulses mid-sweep, write with start, or abort
    task automatic sweep(input logic [4:0] ev [8], input int ec [5], input int stall,
                         input int lat, input bit mid_start, input bit mid_cfg,
                         input bit pre_we, input logic [7:0] pre_mask, input int abort_at);
        int t;
        bit got;
        int npush;
        int stall_cnt;
        exp_t e;
        npush = (abort_at > 0) ? abort_at : 8;
        for (int r = 0; r < npush; r++) begin
            e.row = 3'(r);
            e.val = ev[r];
            sb_q.push_back(e);
        end
        stall_cnt = int'(ev[0][0]) + int'(ev[1][0]);
        out_ready = 1'b1;
        start = 1'b1;
        cfg_we = pre_we; cfg_idx = 3'd0; cfg_mask = pre_mask;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_we = 1'b0;
        chk("first_row_valid", 32'(out_valid), 32'(1));
        chk("busy_in_sweep", 32'(busy), 32'(1));
        t = 0;
        got = 1'b0;
        while (!got && t < 40) begin
            out_ready = !(t >= 2 && t < 2 + stall);
            start = mid_start && (t == 3);
            cfg_we = mid_cfg && (t == 4);
            cfg_idx = 3'd0;
            cfg_mask = 8'hFF;
            if (!out_ready) begin
                cnt_sel = 3'd0;
                #1;
                chk("stall_row", 32'(out_row), 32'(2));
                chk("stall_val", 32'(out_val), 32'(ev[2]));
                chk("stall_cnt", 32'(cnt_out), 32'(stall_cnt));
            end
            if (abort_at > 0 && t == abort_at) begin
                chk("pre_abort_row", 32'(out_row), 32'(abort_at));
                #2 rst = 1'b1;
                #1;
                check_idle_outputs("abort");
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("abort_no_done", 32'(done), 32'(0));
                end
                rst = 1'b0;
                out_ready = 1'b1;
                start = 1'b0;
                cfg_we = 1'b0;
                @(posedge clk); #1;
                chk("abort_no_done_after", 32'(done), 32'(0));
                chk("abort_sb_drained", 32'(sb_q.size()), 32'(0));
                sb_q.delete();
                return;
            end
            @(posedge clk); #1;
            t++;
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        cfg_we = 1'b0;
        out_ready = 1'b1;
        chk("done_latency", 32'(t), 32'(lat));
        chk("done_valid_low", 32'(out_valid), 32'(0));
        chk("done_busy_low", 32'(busy), 32'(0));
        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        sb_q.delete();
        check_counts("count_at_done", ec);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'(0));
    endtask

    initial begin
        // Asynchronous reset asserted mid-cycle
        #3 rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Load masks; index 7 must not touch anything
        wr(3'd0, 8'h8A);
        wr(3'd1, 8'h54);
        wr(3'd2, 8'hB4);
        wr(3'd3, 8'h8E);
        wr(3'd4, 8'hC5);
        wr(3'd7, 8'hFF);

        sweep(ev_def, ec_def, 0, 8, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        for (int s = 5; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            chk("cnt_sel_invalid", 32'(cnt_out), 32'(0));
        end

        sweep(ev_def, ec_def, 3, 11, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        sweep(ev_def, ec_def, 0, 8, 1'b1, 1'b0, 1'b0, 8'h00, 0);
        sweep(ev_def, ec_def, 0, 8, 1'b0, 1'b1, 1'b0, 8'h00, 0);

        // Write f0 = FF together with start: the sweep uses the new mask
        sweep(ev_ff, ec_ff, 0, 8, 1'b0, 1'b0, 1'b1, 8'hFF, 0);
        repeat (4) @(posedge clk);
        #1;
        check_counts("count_hold_idle", ec_ff);

        // Restore f0 with start, then abort at row 5; masks clear so next sweep is all zero
        sweep(ev_def, ec_def, 0, 8, 1'b0, 1'b0, 1'b1, 8'h8A, 5);
        sweep(ev_zero, ec_zero, 0, 8, 1'b0, 1'b0, 1'b0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
